// File: rtl/booth_mult_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// BOOTH_MULT_RADIX4_EN selects radix-4 recoding; radix-2 is the default build.
package booth_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    ADD_M  = 3'd1,
    SUB_M  = 3'd2,
    ADD_2M = 3'd3,
    SUB_2M = 3'd4
  } booth_op_e;

`ifdef BOOTH_MULT_RADIX4_EN
  localparam int WINDOW = 3;
`else
  localparam int WINDOW = 2;
`endif

  // Steps per product; operands are extended by two bits before recoding.
  function automatic int iter_count(input int width);
`ifdef BOOTH_MULT_RADIX4_EN
    return (width + 2) / 2;
`else
    return width + 2;
`endif
  endfunction

endpackage

// File: rtl/booth_mult_seq_recoder.sv
// Combinational Booth recoder: multiplier window to accumulator operation.
// Window is 3 bits with BOOTH_MULT_RADIX4_EN, 2 bits otherwise.
module booth_recoder
  import booth_mult_pkg::*;
(
  input  logic [WINDOW-1:0] bits,
  output booth_op_e         op
);

  // Map the examined multiplier bits (LSB is the guard bit) to an operation.
  always_comb begin
    op = ZERO;
`ifdef BOOTH_MULT_RADIX4_EN
    case (bits)
      3'b000:  op = ZERO;
      3'b001:  op = ADD_M;
      3'b010:  op = ADD_M;
      3'b011:  op = ADD_2M;
      3'b100:  op = SUB_2M;
      3'b101:  op = SUB_M;
      3'b110:  op = SUB_M;
      3'b111:  op = ZERO;
      default: op = ZERO;
    endcase
`else
    case (bits)
      2'b00:   op = ZERO;
      2'b01:   op = ADD_M;
      2'b10:   op = SUB_M;
      2'b11:   op = ZERO;
      default: op = ZERO;
    endcase
`endif
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed/unsigned Booth multiplier with start/busy/done handshake.
// BOOTH_MULT_RADIX4_EN selects radix-4 recoding (half the steps, same results).
module booth_mult_seq
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] high,
  output logic [WIDTH-1:0] low
);

  localparam int E    = WIDTH + 2;
  localparam int ITER = iter_count(WIDTH);
  localparam int CW   = $clog2(ITER + 1);

  state_e           state_r;
  logic [CW-1:0]    cnt_r;
  logic [E:0]       acc_r;
  logic [E-1:0]     mq_r;
  logic             guard_r;
  logic [E-1:0]     mcand_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] high_r;
  logic [WIDTH-1:0] low_r;

  logic [E-1:0]       a_ext_s;
  logic [E-1:0]       b_ext_s;
  logic [WINDOW-1:0]  window_s;
  booth_op_e          op_s;
  logic [E:0]         m1_s;
  logic [E:0]         m2_s;
  logic [E:0]         addend_s;
  logic [E:0]         sum_s;
  logic [E:0]         nacc_s;
  logic [E-1:0]       nmq_s;
  logic               nguard_s;
  logic [2*WIDTH-1:0] product_s;

  assign busy = busy_r;
  assign done = done_r;
  assign high = high_r;
  assign low  = low_r;

`ifdef BOOTH_MULT_RADIX4_EN
  assign window_s = {mq_r[1:0], guard_r};
`else
  assign window_s = {mq_r[0], guard_r};
`endif

  booth_recoder u_recoder (
    .bits (window_s),
    .op   (op_s)
  );

  // Operand extension: one signed algorithm serves both modes.
  always_comb begin
    if (is_signed) begin
      a_ext_s = {{2{a[WIDTH-1]}}, a};
      b_ext_s = {{2{b[WIDTH-1]}}, b};
    end else begin
      a_ext_s = {2'b00, a};
      b_ext_s = {2'b00, b};
    end
  end

  // Accumulator adder and arithmetic shift of {acc, multiplier, guard}.
  always_comb begin
    m1_s     = {mcand_r[E-1], mcand_r};
    m2_s     = {mcand_r, 1'b0};
    addend_s = {(E+1){1'b0}};
    case (op_s)
      ZERO:    addend_s = {(E+1){1'b0}};
      ADD_M:   addend_s = m1_s;
      SUB_M:   addend_s = ~m1_s + (E+1)'(1);
      ADD_2M:  addend_s = m2_s;
      SUB_2M:  addend_s = ~m2_s + (E+1)'(1);
      default: addend_s = {(E+1){1'b0}};
    endcase
    sum_s = acc_r + addend_s;
`ifdef BOOTH_MULT_RADIX4_EN
    nacc_s   = {{2{sum_s[E]}}, sum_s[E:2]};
    nmq_s    = {sum_s[1:0], mq_r[E-1:2]};
    nguard_s = mq_r[1];
`else
    nacc_s   = {sum_s[E], sum_s[E:1]};
    nmq_s    = {sum_s[0], mq_r[E-1:1]};
    nguard_s = mq_r[0];
`endif
  end

  // The 2E-bit product's top four bits are pure sign extension and dropped.
  assign product_s = {acc_r[WIDTH-3:0], mq_r};

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      acc_r   <= {(E+1){1'b0}};
      mq_r    <= {E{1'b0}};
      guard_r <= 1'b0;
      mcand_r <= {E{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      high_r  <= {WIDTH{1'b0}};
      low_r   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            mcand_r <= a_ext_s;
            mq_r    <= b_ext_s;
            acc_r   <= {(E+1){1'b0}};
            guard_r <= 1'b0;
            cnt_r   <= CW'(ITER);
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          acc_r   <= nacc_s;
          mq_r    <= nmq_s;
          guard_r <= nguard_s;
          cnt_r   <= cnt_r - CW'(1);
          busy_r  <= 1'b1;
          done_r  <= 1'b0;
          if (cnt_r == CW'(1)) begin
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          high_r  <= product_s[2*WIDTH-1:WIDTH];
          low_r   <= product_s[WIDTH-1:0];
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential Booth multiplier; the next-generation replacement for the fixed 32-bit multiplier in the datapath's HI/LO unit. It accepts a start pulse, multiplies two WIDTH-bit operands as signed or unsigned, and delivers a 2·WIDTH-bit product split into high/low words with a one-cycle done pulse. It has an explicit busy/start handshake and defined abort-on-reset behaviour. It is the multiply engine behind the control unit's MULT/MULTU states.

## Interface
- WIDTH, 32, operand width; must be even and ≥ 4
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while idle
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
- a  in  WIDTH  multiplicand; captured with start
- b  in  WIDTH  multiplier; captured with start
- busy  out  1  high whenever not idle
- done  out  1  one-cycle pulse; result valid
- high  out  WIDTH  product bits [2·WIDTH-1:WIDTH]
- low  out  WIDTH  product bits [WIDTH-1:0]

## Operation
- Reset values: busy=0, done=0, high=0, low=0, state IDLE, internal accumulator and counter cleared.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 → capture operands, load counter with ITER, go to RUN.
  - RUN: one Booth step per edge; on the edge where the counter reaches 0, go to DONE.
  - DONE: write high/low, assert done for exactly one cycle, go to IDLE.
- Extension: both operands extended to E = WIDTH+2 bits. Sign-extend when is_signed=1; zero-extend otherwise. One algorithm serves both modes.
- Product register: multiplicand-side accumulator (E+1 bits), multiplier (E bits), plus one guard bit.
- Every shift is arithmetic: sign bit replicated.
- Result is the low 2·WIDTH bits of the 2E-bit product. Overflow is impossible in either mode.
- start while busy=1: ignored, no effect on the operation in progress.
- Operand inputs are don't-care after the capture edge.
- high/low hold their last result until the next DONE or reset. They never show intermediate values.
- reset=1 in any state: abort immediately, return to reset values, no done pulse.
- reset and start in the same cycle: reset wins and start is dropped.

## Timing
- ITER = E (radix-2) or E/2 (radix-4, see Configuration).
- Start accepted at edge N:
  - busy=1 from after edge N.
  - high/low updated and done=1 after edge N+ITER+1.
  - done=0 and busy=0 after edge N+ITER+2.
- busy and done are never high together.
- busy is low during the done cycle, so start may be held high then. It is accepted at the following edge, giving a minimum start-to-start spacing of ITER+2 cycles.
- WIDTH=32:
  - radix-2: ITER=34, done 35 edges after accept.
  - radix-4: ITER=17, done 18 edges after accept.

## Configuration
- BOOTH_MULT_RADIX4_EN defined: radix-4 (modified Booth) recoding.
  - Examines 3 multiplier bits per step and adds 0, ±M or ±2M.
  - Shifts by 2 per step; ITER = E/2.
- Not defined: radix-2 Booth.
  - Examines 2 bits per step and adds 0 or ±M.
  - Shifts by 1 per step; ITER = E.
- Both builds produce identical results and identical handshake behaviour; only latency differs.

## Structure
- Package booth_mult_pkg:
  - state enum (IDLE, RUN, DONE)
  - Booth operation enum (ZERO, ADD_M, SUB_M, ADD_2M, SUB_2M)
  - function iter_count(width) honouring the macro
- Sub-module booth_recoder: combinational. Maps the examined multiplier bits to a Booth operation (2-bit window radix-2, 3-bit window radix-4).
- The top module holds the FSM, counter, product register and adder.

## Test plan
- Signed: is_signed=1, a=-7 (0xFFFFFFF9), b=3 → high=0xFFFFFFFF, low=0xFFFFFFEB; done exactly once, at the latency given in Timing for the build.
- Unsigned: is_signed=0, a=b=0xFFFFFFFF → high=0xFFFFFFFE, low=0x00000001. Same operands with is_signed=1 → high=0, low=1.
- Corner: is_signed=1, a=b=0x80000000 → high=0x40000000, low=0.
- Handshake: start pulsed again 5 cycles into an operation with different operands → ignored; first result delivered, single done. Start held during the done cycle → second operation accepted at the next edge.
- Reset abort: reset asserted 10 cycles after start → busy=0, high=low=0, no done. A new start afterwards computes 6×7 → low=42, high=0.
- Random: 10,000 random operand/mode pairs checked against a reference product, in both macro builds, with WIDTH=32 and WIDTH=8.
